// File: rtl/rr_mux_reg.sv
// N-input registered mux with round-robin or fixed-priority arbitration; 1-cycle latency, full throughput.
// Backpressure: a held output (out_valid & ~out_ready) forces every in_ready low and freezes the pointer.
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter bit RR    = 1'b1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] gnt_idx;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] gnt_data;
  logic             any_gnt;
  logic             can_load;

  assign can_load = ~out_valid | out_ready;

  // Scan starts at ptr; with fixed priority ptr stays 0, so this is lowest-index-wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_data = '0;
    any_gnt  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = SEL_W'((int'(ptr) + k) % N);
      if (!any_gnt && in_valid[scan_idx]) begin
        any_gnt           = 1'b1;
        grant[scan_idx]   = 1'b1;
        gnt_idx           = scan_idx;
        gnt_data          = in_data[scan_idx*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst_n so no producer sees a handshake while the block is held in reset.
  assign in_ready = grant & {N{can_load & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (can_load && any_gnt) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt_idx;
      if (RR)
        ptr <= (gnt_idx == SEL_W'(N-1)) ? '0 : SEL_W'(gnt_idx + 1'b1);
      else
        ptr <= '0;
    end else if (can_load) begin
      out_valid <= 1'b0;
    end
  end

endmodule
